// File: rtl/particle_pkg.sv
// particle_pkg: shared buffer geometry, latency constants and sweep state encoding.
package particle_pkg;
  localparam int RAM_WIDTH = 18;
  localparam int RAM_DEPTH = 1024;
  localparam int ADDR_W = $clog2(RAM_DEPTH);
  localparam int READ_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} sweep_state_e;
endpackage

// File: rtl/particle_skid_fifo.sv
// particle_skid_fifo: synchronous FIFO with occupancy count and same-cycle push/pop.
module particle_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop = pop && cnt_q != '0;
    do_push = push && (cnt_q != CW'(DEPTH) || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = din;
    wp_d = flush ? '0 : do_push ? inc(wp_q) : wp_q;
    rp_d = flush ? '0 : do_pop ? inc(rp_q) : rp_q;
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = mem_q[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/particle_sweep_controller.sv
// particle_sweep_controller: streams buffer entries 0..N-1 to the update engine and
// writes results back, hiding port A read latency behind a credit-limited FIFO.
module particle_sweep_controller #(
  parameter int RAM_WIDTH = particle_pkg::RAM_WIDTH,
  parameter int RAM_DEPTH = particle_pkg::RAM_DEPTH,
  parameter int ADDR_W = $clog2(RAM_DEPTH),
  parameter int READ_LATENCY = particle_pkg::READ_LATENCY,
  parameter int FIFO_DEPTH = particle_pkg::FIFO_DEPTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [ADDR_W:0]      count_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [ADDR_W-1:0]    addra_out,
  output logic                 ena_out,
  output logic                 regcea_out,
  input  logic [RAM_WIDTH-1:0] douta_in,
  output logic [RAM_WIDTH-1:0] part_data_out,
  output logic [ADDR_W-1:0]    part_addr_out,
  output logic                 part_valid_out,
  input  logic                 part_ready_in,
  input  logic [RAM_WIDTH-1:0] res_data_in,
  input  logic [ADDR_W-1:0]    res_addr_in,
  input  logic                 res_valid_in,
  output logic                 res_ready_out,
  output logic [ADDR_W-1:0]    addrb_out,
  output logic [RAM_WIDTH-1:0] dinb_out,
  output logic                 enb_out,
  output logic                 web_out
);
  import particle_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = RAM_WIDTH + ADDR_W;

  sweep_state_e state_q, state_d;
  logic [ADDR_W:0] n_q, n_d, rd_ptr_q, rd_ptr_d, wr_cnt_q, wr_cnt_d, n_clamp;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0] lat_addr_q [READ_LATENCY];
  logic [ADDR_W-1:0] lat_addr_d [READ_LATENCY];
  logic regcea_q;
  logic [CW-1:0] fifo_cnt;
  logic [FW-1:0] fifo_dout;
  logic accept, issue, wr, pop, active;

  always_comb begin
    n_clamp = (count_in > (ADDR_W+1)'(RAM_DEPTH)) ? (ADDR_W+1)'(RAM_DEPTH) : count_in;
    accept = state_q == S_IDLE && start_in;
    active = state_q == S_SWEEP || state_q == S_DRAIN;
    // Credit covers both reads still in the BRAM pipe and entries already queued.
    issue = state_q == S_SWEEP && rd_ptr_q < n_q &&
            ($countones(vld_q) + int'(fifo_cnt) < FIFO_DEPTH);
    wr = active && res_valid_in;
    pop = part_valid_out && part_ready_in;
    n_d = accept ? n_clamp : n_q;
    rd_ptr_d = accept ? '0 : rd_ptr_q + (ADDR_W+1)'(issue);
    wr_cnt_d = accept ? '0 : wr_cnt_q + (ADDR_W+1)'(wr);
    vld_d = (vld_q << 1) | READ_LATENCY'(issue);
    lat_addr_d[0] = rd_ptr_q[ADDR_W-1:0];
    for (int i = 1; i < READ_LATENCY; i++) lat_addr_d[i] = lat_addr_q[i-1];
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = accept ? (n_clamp == '0 ? S_DONE : S_SWEEP) : S_IDLE;
      S_SWEEP: state_d = rd_ptr_d == n_q ? (wr_cnt_d == n_q ? S_DONE : S_DRAIN) : S_SWEEP;
      S_DRAIN: state_d = wr_cnt_d == n_q ? S_DONE : S_DRAIN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      n_q <= '0;
      rd_ptr_q <= '0;
      wr_cnt_q <= '0;
      vld_q <= '0;
      regcea_q <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) lat_addr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      rd_ptr_q <= rd_ptr_d;
      wr_cnt_q <= wr_cnt_d;
      vld_q <= vld_d;
      regcea_q <= issue;
      lat_addr_q <= lat_addr_d;
    end
  end

  particle_skid_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_in),
    .rst(rst_in),
    .flush(accept),
    .push(vld_q[READ_LATENCY-1]),
    .din({douta_in, lat_addr_q[READ_LATENCY-1]}),
    .pop(pop),
    .dout(fifo_dout),
    .count(fifo_cnt)
  );

  assign busy_out = state_q != S_IDLE;
  assign done_out = state_q == S_DONE;
  assign ena_out = issue;
  assign addra_out = issue ? rd_ptr_q[ADDR_W-1:0] : '0;
  assign regcea_out = regcea_q;
  assign part_valid_out = fifo_cnt != '0;
  assign part_data_out = part_valid_out ? fifo_dout[FW-1:ADDR_W] : '0;
  assign part_addr_out = part_valid_out ? fifo_dout[ADDR_W-1:0] : '0;
  assign res_ready_out = active;
  assign enb_out = wr;
  assign web_out = wr;
  assign addrb_out = wr ? res_addr_in : '0;
  assign dinb_out = wr ? res_data_in : '0;
endmodule
